// File: rtl/corner_finder_pkg.sv
// Shared constants and helpers for the corner finder: corner indices, slot
// positions within the packed coordinate bus, and per-corner metric selection.
package corner_finder_pkg;

  localparam int P_BIT_WIDTH_DEFAULT = 11;
  localparam int NUM_CORNERS         = 4;

  localparam int CORNER_TL = 0;
  localparam int CORNER_TR = 1;
  localparam int CORNER_BL = 2;
  localparam int CORNER_BR = 3;

  // LSB position of coordinate slot k in a bus of w-bit coordinates.
  function automatic int slot_lsb(input int k, input int w);
    return k * w;
  endfunction

  // TR/BL rank on x-y; TL/BR rank on x+y.
  function automatic bit corner_uses_diff(input int c);
    return (c == CORNER_TR) || (c == CORNER_BL);
  endfunction

  function automatic bit corner_maximises(input int c);
    return (c == CORNER_TR) || (c == CORNER_BR);
  endfunction

endpackage

// File: rtl/corner_finder_if.sv
// Video-side input and per-frame coordinate output bundle of the corner finder.
interface corner_finder_if #(
  parameter int p_bit_width       = 11,
  parameter int p_num_coordinates = 8
);
  logic                                     VGA_BLANK_N;
  logic                                     VGA_VS;
  logic                                     data_in;
  logic [p_num_coordinates*p_bit_width-1:0] data_out;
  logic                                     frame_valid;
  logic                                     corner_found;

  modport master (
    output VGA_BLANK_N, VGA_VS, data_in,
    input  data_out, frame_valid, corner_found
  );

  modport slave (
    input  VGA_BLANK_N, VGA_VS, data_in,
    output data_out, frame_valid, corner_found
  );
endinterface

// File: rtl/corner_finder_tracker.sv
// Tracks the mask pixel with the best x+y or x-y metric seen since the last
// clear; strict comparison keeps the earliest pixel in raster order on ties.
module corner_tracker
  import corner_finder_pkg::*;
#(
  parameter int p_bit_width = P_BIT_WIDTH_DEFAULT,
  parameter bit p_use_diff  = 1'b0,
  parameter bit p_maximise  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   hit_en,
  input  logic [p_bit_width-1:0] x,
  input  logic [p_bit_width-1:0] y,
  output logic [p_bit_width-1:0] best_x,
  output logic [p_bit_width-1:0] best_y
);

  logic [p_bit_width:0]   metric;
  logic [p_bit_width:0]   best_metric_reg;
  logic [p_bit_width-1:0] best_x_reg;
  logic [p_bit_width-1:0] best_y_reg;
  logic                   occupied_reg;
  logic                   better;
  logic                   load;

  // x-y is one bit wider than the coordinates so it is exact as two's complement.
  generate
    if (p_use_diff) begin : g_diff
      assign metric = {1'b0, x} - {1'b0, y};
      if (p_maximise) begin : g_max
        assign better = $signed(metric) > $signed(best_metric_reg);
      end else begin : g_min
        assign better = $signed(metric) < $signed(best_metric_reg);
      end
    end else begin : g_sum
      assign metric = {1'b0, x} + {1'b0, y};
      if (p_maximise) begin : g_max
        assign better = metric > best_metric_reg;
      end else begin : g_min
        assign better = metric < best_metric_reg;
      end
    end
  endgenerate

  // A clear coincident with a hit seeds the tracker with that hit.
  assign load = hit_en & (clr | ~occupied_reg | better);

  always_ff @(posedge clk) begin
    if (reset) begin
      best_metric_reg <= '0;
      best_x_reg      <= '0;
      best_y_reg      <= '0;
      occupied_reg    <= 1'b0;
    end else if (load) begin
      best_metric_reg <= metric;
      best_x_reg      <= x;
      best_y_reg      <= y;
      occupied_reg    <= 1'b1;
    end else if (clr) begin
      best_metric_reg <= '0;
      best_x_reg      <= '0;
      best_y_reg      <= '0;
      occupied_reg    <= 1'b0;
    end
  end

  assign best_x = best_x_reg;
  assign best_y = best_y_reg;

endmodule

// File: rtl/corner_finder.sv
// Finds the four extreme pixels of a 1-bit mask per video frame and publishes
// their coordinates one clock after the falling edge of VGA_VS.
module corner_finder
  import corner_finder_pkg::*;
#(
  parameter int p_bit_width       = P_BIT_WIDTH_DEFAULT,
  parameter int p_h_active        = 640,
  parameter int p_v_active        = 480,
  parameter int p_num_coordinates = 8
) (
  input logic             clk,
  input logic             reset,
  corner_finder_if.slave  bus
);

  generate
    if (p_num_coordinates != 2 * NUM_CORNERS) begin : g_bad_coordinates
      $error("corner_finder: p_num_coordinates must be 8");
    end
  endgenerate

  localparam int DATA_WIDTH = p_num_coordinates * p_bit_width;
  localparam logic [p_bit_width-1:0] h_limit   = p_bit_width'(p_h_active);
  localparam logic [p_bit_width-1:0] v_limit   = p_bit_width'(p_v_active);
  localparam logic [p_bit_width-1:0] coord_one = {{(p_bit_width-1){1'b0}}, 1'b1};

  logic                   vs_prev_reg;
  logic                   blank_prev_reg;
  logic [p_bit_width-1:0] x_cnt_reg;
  logic [p_bit_width-1:0] y_cnt_reg;
  logic                   any_hit_reg;
  logic [DATA_WIDTH-1:0]  data_out_reg;
  logic                   frame_valid_reg;
  logic                   corner_found_reg;

  logic                   vs_fall;
  logic                   blank_fall;
  logic [p_bit_width-1:0] pix_x;
  logic [p_bit_width-1:0] pix_y;
  logic                   hit;
  logic [DATA_WIDTH-1:0]  corners_packed;
  logic [p_bit_width-1:0] best_x [NUM_CORNERS];
  logic [p_bit_width-1:0] best_y [NUM_CORNERS];

  assign vs_fall    = vs_prev_reg & ~bus.VGA_VS;
  assign blank_fall = blank_prev_reg & ~bus.VGA_BLANK_N;

  // A pixel arriving with the frame boundary is the origin of the new frame.
  always_comb begin
    pix_x = x_cnt_reg;
    pix_y = y_cnt_reg;
    if (vs_fall) begin
      pix_x = '0;
      pix_y = '0;
    end
    hit = bus.VGA_BLANK_N & bus.data_in & (pix_x < h_limit) & (pix_y < v_limit);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORNERS; gi++) begin : g_corner
      localparam int lsb_x = slot_lsb(2 * gi,     p_bit_width);
      localparam int lsb_y = slot_lsb(2 * gi + 1, p_bit_width);

      corner_tracker #(
        .p_bit_width (p_bit_width),
        .p_use_diff  (corner_uses_diff(gi)),
        .p_maximise  (corner_maximises(gi))
      ) u_tracker (
        .clk    (clk),
        .reset  (reset),
        .clr    (vs_fall),
        .hit_en (hit),
        .x      (pix_x),
        .y      (pix_y),
        .best_x (best_x[gi]),
        .best_y (best_y[gi])
      );

      assign corners_packed[lsb_x +: p_bit_width] = best_x[gi];
      assign corners_packed[lsb_y +: p_bit_width] = best_y[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev_reg      <= 1'b0;
      blank_prev_reg   <= 1'b0;
      x_cnt_reg        <= '0;
      y_cnt_reg        <= '0;
      any_hit_reg      <= 1'b0;
      data_out_reg     <= '0;
      frame_valid_reg  <= 1'b0;
      corner_found_reg <= 1'b0;
    end else begin
      vs_prev_reg     <= bus.VGA_VS;
      blank_prev_reg  <= bus.VGA_BLANK_N;
      frame_valid_reg <= vs_fall;
      if (vs_fall) begin
        if (any_hit_reg) begin
          data_out_reg <= corners_packed;
        end
        corner_found_reg <= any_hit_reg;
        any_hit_reg      <= hit;
        y_cnt_reg        <= '0;
        x_cnt_reg        <= bus.VGA_BLANK_N ? coord_one : '0;
      end else begin
        if (hit) begin
          any_hit_reg <= 1'b1;
        end
        if (blank_fall) begin
          x_cnt_reg <= '0;
          if (y_cnt_reg < v_limit) begin
            y_cnt_reg <= y_cnt_reg + coord_one;
          end
        end else if (bus.VGA_BLANK_N && (x_cnt_reg < h_limit)) begin
          // Saturating at the active width keeps over-long lines out of range.
          x_cnt_reg <= x_cnt_reg + coord_one;
        end
      end
    end
  end

  assign bus.data_out     = data_out_reg;
  assign bus.frame_valid  = frame_valid_reg;
  assign bus.corner_found = corner_found_reg;

endmodule

// File: tb/tb_corner_finder.sv
// Directed bench for corner_finder: table of whole frames with hand-computed
// corners, plus sequences for boundary pixels and reset in mid-frame.
module tb_corner_finder;

  localparam int W  = 11;
  localparam int DW = 8 * W;

  typedef struct packed {
    logic [3:0]    mode;
    logic          exp_found;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   fv_count = 0;

  corner_finder_if #(.p_bit_width(W), .p_num_coordinates(8)) bus ();

  corner_finder #(
    .p_bit_width       (W),
    .p_h_active        (640),
    .p_v_active        (480),
    .p_num_coordinates (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack8(input int c0, input int c1, input int c2, input int c3,
                                         input int c4, input int c5, input int c6, input int c7);
    int c [8];
    logic [DW-1:0] r;
    c = '{c0, c1, c2, c3, c4, c5, c6, c7};
    r = '0;
    for (int k = 0; k < 8; k++) r[k*W +: W] = c[k][W-1:0];
    return r;
  endfunction

  function automatic int last_line(input int mode);
    case (mode)
      1: return 50;
      2: return 179;
      3: return 20;
      4: return 481;
      5: return 60;
      6: return 199;
      default: return 3;
    endcase
  endfunction

  function automatic int line_len(input int mode, input int y);
    case (mode)
      1: return (y == 50) ? 101 : 1;
      2: return (y >= 100) ? 300 : 1;
      3: return (y == 10 || y == 20) ? 21 : 1;
      4: return (y == 20 || y == 40) ? 641 : ((y >= 480) ? 6 : 1);
      5: return (y == 60) ? 61 : 1;
      default: return 1;
    endcase
  endfunction

  function automatic bit mask_at(input int mode, input int x, input int y);
    case (mode)
      1: return (x == 100) && (y == 50);
      2: return (x >= 200) && (x <= 299) && (y >= 100) && (y <= 179);
      3: return ((x == 20) && (y == 10)) || ((x == 10) && (y == 20));
      4: return ((x == 30) && (y == 40)) || ((x == 640) && (y == 40 || y == 20)) ||
                ((x == 5) && (y >= 480));
      5: return (x == 50) && (y == 60);
      6: return (x == 0) && (y == 5);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_lines(input int mode, input int y_first, input int y_last);
    for (int y = y_first; y <= y_last; y++) begin
      for (int x = 0; x < line_len(mode, y); x++) begin
        bus.VGA_BLANK_N = 1'b1;
        bus.data_in     = mask_at(mode, x, y);
        tick();
      end
      bus.VGA_BLANK_N = 1'b0;
      bus.data_in     = 1'b0;
      tick();
    end
  endtask

  // Leaves time just after the clock edge that sees the VS falling edge.
  task automatic end_frame(input bit coincident_pixel);
    bus.VGA_VS = 1'b1;
    tick();
    tick();
    bus.VGA_VS      = 1'b0;
    bus.VGA_BLANK_N = coincident_pixel;
    bus.data_in     = coincident_pixel;
    tick();
    bus.VGA_BLANK_N = 1'b0;
    bus.data_in     = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [DW-1:0] exp_data, input logic exp_found);
    $display("frame %s: data_out=%h corner_found=%0b frame_valid=%0b",
             name, bus.data_out, bus.corner_found, bus.frame_valid);
    check({name, " data_out"}, bus.data_out, exp_data);
    check({name, " corner_found"}, DW'(bus.corner_found), DW'(exp_found));
    check({name, " frame_valid_pulse"}, DW'(bus.frame_valid), DW'(1'b1));
    tick();
    check({name, " frame_valid_one_cycle"}, DW'(bus.frame_valid), DW'(1'b0));
    check({name, " data_out_held"}, bus.data_out, exp_data);
  endtask

  vec_t vecs [5];
  logic [DW-1:0] rect_data;
  int fv_before;

  initial begin
    bus.VGA_BLANK_N = 1'b0;
    bus.VGA_VS      = 1'b0;
    bus.data_in     = 1'b0;

    rect_data = pack8(200, 100, 299, 100, 200, 179, 299, 179);
    vecs[0] = '{mode: 4'd1, exp_found: 1'b1, exp_data: pack8(100, 50, 100, 50, 100, 50, 100, 50)};
    vecs[1] = '{mode: 4'd2, exp_found: 1'b1, exp_data: rect_data};
    vecs[2] = '{mode: 4'd0, exp_found: 1'b0, exp_data: rect_data};
    vecs[3] = '{mode: 4'd3, exp_found: 1'b1, exp_data: pack8(20, 10, 20, 10, 10, 20, 20, 10)};
    vecs[4] = '{mode: 4'd4, exp_found: 1'b1, exp_data: pack8(30, 40, 30, 40, 30, 40, 30, 40)};

    tick();
    tick();
    check("reset data_out", bus.data_out, '0);
    check("reset frame_valid", DW'(bus.frame_valid), '0);
    check("reset corner_found", DW'(bus.corner_found), '0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      drive_lines(int'(vecs[i].mode), 0, last_line(int'(vecs[i].mode)));
      end_frame(1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_found);
    end

    // Pixel arriving with the VS edge is excluded here and seeds the next frame at (0,0).
    drive_lines(5, 0, last_line(5));
    end_frame(1'b1);
    check_frame("coincident_old", pack8(50, 60, 50, 60, 50, 60, 50, 60), 1'b1);
    drive_lines(0, 0, last_line(0));
    end_frame(1'b0);
    check_frame("coincident_new", '0, 1'b1);

    // Reset at line 200 with a VS edge while in reset; only the next frame reports.
    drive_lines(6, 0, last_line(6));
    fv_before = fv_count;
    reset = 1'b1;
    tick();
    bus.VGA_VS = 1'b1;
    tick();
    tick();
    bus.VGA_VS = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("after_reset data_out", bus.data_out, '0);
    check("after_reset corner_found", DW'(bus.corner_found), '0);
    check("after_reset frame_valid", DW'(bus.frame_valid), '0);
    tick();
    check("aborted frame pulses", DW'(fv_count - fv_before), '0);
    drive_lines(2, 0, last_line(2));
    end_frame(1'b0);
    check_frame("post_reset_rect", rect_data, 1'b1);
    check("post_reset pulse count", DW'(fv_count - fv_before), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
